// File: rtl/click_pipe.sv
// click_pipe: a chain of DEPTH click stages, each holding one WIDTH-bit token,
// clocked inside a single synchronous domain. Both ends use a two-phase
// (transition-signalled) bundled-data handshake: every toggle of a request
// offers one token, and every toggle of the matching acknowledge consumes it.
//
// Optional feature macro: CLICK_PIPE_SYNC_EN. When it is defined, in_reqL and
// in_ackR each pass through a 2-flop synchronizer before they are used. This
// adds 2 cycles to each latency. in_dataL is never synchronized, because the
// bundled-data hold rule keeps it stable while it is in use.
//
// Ports:
//   i_clk      clock; all state changes on the rising edge
//   i_rst      asynchronous active-high reset
//   in_reqL    left request phase (one token per toggle)
//   in_dataL   left data, bundled with in_reqL
//   out_ackL   left acknowledge phase (= phase of stage 0)
//   out_reqR   right request phase (= phase of stage DEPTH-1)
//   out_dataR  right data (= data register of stage DEPTH-1)
//   in_ackR    right acknowledge phase
//   o_click    registered per-stage fire pulses
//   o_count    number of full stages (0..DEPTH), combinational
module click_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       in_reqL,
    input  logic [WIDTH-1:0]           in_dataL,
    output logic                       out_ackL,
    output logic                       out_reqR,
    output logic [WIDTH-1:0]           out_dataR,
    input  logic                       in_ackR,
    output logic [DEPTH-1:0]           o_click,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic                     req_s;
    logic                     ack_s;
    logic [DEPTH-1:0]         ph_q;
    logic [DEPTH-1:0]         ph_d;
    logic [DEPTH*WIDTH-1:0]   d_q;
    logic [DEPTH*WIDTH-1:0]   d_d;
    logic [DEPTH-1:0]         click_q;
    logic [DEPTH-1:0]         fire_s;
    logic [DEPTH-1:0]         full_s;
    logic [CW-1:0]            count_s;
    // Bit 0 is the left boundary phase, bits 1..DEPTH are the stages, and
    // bit DEPTH+1 is the right boundary phase.
    logic [DEPTH+1:0]         ph_ext_s;
    // Slot 0 holds the left input data. Slot i+1 holds stage i, so the source
    // for stage i is always slot i.
    logic [(DEPTH+1)*WIDTH-1:0] d_chain_s;

`ifdef CLICK_PIPE_SYNC_EN
    logic [1:0] req_sync_q;
    logic [1:0] ack_sync_q;

    // Two-flop synchronizers for the two boundary phase inputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_sync_q <= 2'b00;
            ack_sync_q <= 2'b00;
        end else begin
            req_sync_q <= {req_sync_q[0], in_reqL};
            ack_sync_q <= {ack_sync_q[0], in_ackR};
        end
    end

    assign req_s = req_sync_q[1];
    assign ack_s = ack_sync_q[1];
`else
    assign req_s = in_reqL;
    assign ack_s = in_ackR;
`endif

    assign ph_ext_s  = {ack_s, ph_q, req_s};
    assign d_chain_s = {d_q, in_dataL};

    // Fire and full conditions for each stage, evaluated from registered state
    always_comb begin
        fire_s = {DEPTH{1'b0}};
        full_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            // The left neighbour offers a token and this stage is empty.
            fire_s[i] = (ph_ext_s[i] != ph_ext_s[i+1]) &&
                        (ph_ext_s[i+1] == ph_ext_s[i+2]);
            full_s[i] = (ph_ext_s[i+1] != ph_ext_s[i+2]);
        end
    end

    // Next phase and data: each firing stage toggles and captures its source
    always_comb begin
        ph_d = ph_q ^ fire_s;
        d_d  = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (fire_s[i]) begin
                d_d[i*WIDTH +: WIDTH] = d_chain_s[i*WIDTH +: WIDTH];
            end else begin
                d_d[i*WIDTH +: WIDTH] = d_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy count: popcount of the full stages
    always_comb begin
        count_s = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            count_s = count_s + CW'(full_s[i]);
        end
    end

    // Stage phase, data and fire-pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ph_q    <= {DEPTH{1'b0}};
            d_q     <= {(DEPTH*WIDTH){1'b0}};
            click_q <= {DEPTH{1'b0}};
        end else begin
            ph_q    <= ph_d;
            d_q     <= d_d;
            click_q <= fire_s;
        end
    end

    assign out_ackL  = ph_q[0];
    assign out_reqR  = ph_q[DEPTH-1];
    assign out_dataR = d_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign o_click   = click_q;
    assign o_count   = count_s;

endmodule

// File: tb/tb_click_pipe.sv
module tb_click_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          in_reqL = 1'b0;
    logic [W-1:0]  in_dataL = 8'h00;
    logic          in_ackR = 1'b0;
    logic          out_ackL;
    logic          out_reqR;
    logic [W-1:0]  out_dataR;
    logic [D-1:0]  o_click;
    logic [CW-1:0] o_count;

    click_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .in_reqL  (in_reqL),
        .in_dataL (in_dataL),
        .out_ackL (out_ackL),
        .out_reqR (out_reqR),
        .out_dataR(out_dataR),
        .in_ackR  (in_ackR),
        .o_click  (o_click),
        .o_count  (o_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Token-slot reference model: each slot is empty or holds a value, and a
    // token advances into an empty slot from the slot (or producer) behind it.
    bit           m_occ[D];
    logic [W-1:0] m_val[D];
    bit           m_pend;
    logic [W-1:0] m_pdata;
    int           m_acc;
    int           m_arr;
    logic [D-1:0] m_click;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         req;
        logic         ack;
        logic [W-1:0] data;
        logic         e_ackL;
        logic         e_reqR;
        logic [W-1:0] e_dataR;
        logic [D-1:0] e_click;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_occ[i] = 1'b0;
            m_val[i] = 8'h00;
        end
        m_pend  = 1'b0;
        m_pdata = 8'h00;
        m_acc   = 0;
        m_arr   = 0;
        m_click = 4'b0000;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit mv[D];
        for (int i = 0; i < D; i++) begin
            mv[i] = ((i == 0) ? m_pend : m_occ[i-1]) && !m_occ[i];
        end
        for (int i = D - 1; i >= 0; i--) begin
            m_click[i] = mv[i];
            if (mv[i]) begin
                m_occ[i] = 1'b1;
                if (i == 0) begin
                    m_val[0] = m_pdata;
                    m_pend   = 1'b0;
                    m_acc++;
                end else begin
                    m_val[i]   = m_val[i-1];
                    m_occ[i-1] = 1'b0;
                end
                if (i == D - 1) m_arr++;
            end
        end
    endtask

    task automatic check_outputs();
        check("ackL",  32'(out_ackL),  32'(m_acc[0]));
        check("reqR",  32'(out_reqR),  32'(m_arr[0]));
        check("dataR", 32'(out_dataR), 32'(m_val[D-1]));
        check("click", 32'(o_click),   32'(m_click));
        check("count", 32'(o_count),   32'(m_count()));
        check("click_adjacent", 32'(o_click & (o_click >> 1)), 32'd0);
    endtask

    // One clock cycle: apply optional legal toggles, clock, compare to model.
    task automatic step(input bit tog_req, input logic [W-1:0] data, input bit tog_ack);
        if (tog_req) begin
            in_reqL  = ~in_reqL;
            in_dataL = data;
            m_pend   = 1'b1;
            m_pdata  = data;
            exp_q.push_back(data);
        end
        if (tog_ack) begin
            if (exp_q.size() == 0) begin
                check("order_underflow", 32'd1, 32'd0);
            end else begin
                check("order", 32'(out_dataR), 32'(exp_q.pop_front()));
            end
            in_ackR  = ~in_ackR;
            m_occ[D-1] = 1'b0;
        end
        @(posedge i_clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        in_reqL = 1'b0;
        in_ackR = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int offered;
        int acks;
        int cycles;
        int got;
        int sent;
        bit r;
        bit a;

        //            req   ack   data   ackL  reqR  dataR  click    cnt
        vt[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b0001, 3'd1};
        vt[1] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b0010, 3'd1};
        vt[2] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b0100, 3'd1};
        vt[3] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'b1000, 3'd1};
        vt[4] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'b0000, 3'd0};
        vt[5] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b0001, 3'd1};
        vt[6] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b0010, 3'd1};
        vt[7] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b0100, 3'd1};
        vt[8] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'b1000, 3'd1};
        vt[9] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'b0000, 3'd0};

        // Asynchronous reset with random producer inputs, before any clock edge
        #2;
        in_dataL = 8'($urandom);
        in_reqL  = 1'($urandom);
        i_rst    = 1'b1;
        #1;
        check("rst_ackL",  32'(out_ackL),  32'd0);
        check("rst_reqR",  32'(out_reqR),  32'd0);
        check("rst_dataR", 32'(out_dataR), 32'd0);
        check("rst_click", 32'(o_click),   32'd0);
        check("rst_count", 32'(o_count),   32'd0);
        do_reset();

        // Single tokens 0xA5 then 0x3C through the empty pipe
        for (int i = 0; i < 10; i++) begin
            in_reqL  = vt[i].req;
            in_ackR  = vt[i].ack;
            in_dataL = vt[i].data;
            @(posedge i_clk);
            #1;
            check($sformatf("vec%0d_ackL", i),  32'(out_ackL),  32'(vt[i].e_ackL));
            check($sformatf("vec%0d_reqR", i),  32'(out_reqR),  32'(vt[i].e_reqR));
            check($sformatf("vec%0d_dataR", i), 32'(out_dataR), 32'(vt[i].e_dataR));
            check($sformatf("vec%0d_click", i), 32'(o_click),   32'(vt[i].e_click));
            check($sformatf("vec%0d_count", i), 32'(o_count),   32'(vt[i].e_cnt));
        end

        // Fill: offer 0x01..0x06 with the right side stalled
        do_reset();
        offered = 0;
        for (int c = 0; c < 30; c++) begin
            r = !m_pend && (offered < 6);
            step(r, 8'(offered + 1), 1'b0);
            if (r) offered++;
        end
        check("fill_count", 32'(o_count), 32'd4);
        check("fill_ackL_frozen", 32'(out_ackL), 32'd0);
        acks = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            r = !m_pend && (offered < 6);
            a = m_occ[D-1];
            step(r, 8'(offered + 1), a);
            if (r) offered++;
            if (a) acks++;
        end
        check("fill_acks_done", 32'(acks), 32'd4);
        for (int c = 0; c < 12; c++) begin
            r = !m_pend && (offered < 6);
            step(r, 8'(offered + 1), 1'b0);
            if (r) offered++;
        end
        check("fill_drain_count", 32'(o_count), 32'd2);
        check("fill_head_data", 32'(out_dataR), 32'h05);

        // Streaming with immediate acknowledge
        do_reset();
        cycles = 0;
        got    = 0;
        sent   = 0;
        while (got < 32 && cycles < 200) begin
            r = !m_pend && (sent < 32);
            a = m_occ[D-1];
            step(r, 8'($urandom), a);
            if (r) sent++;
            if (a) got++;
            cycles++;
        end
        check("stream_done", 32'(got), 32'd32);
        check("stream_throughput", 32'((cycles >= 64) && (cycles <= 68)), 32'd1);

        // Mid-operation reset with 3 tokens held
        do_reset();
        for (int c = 0; c < 30 && m_count() < 3; c++) begin
            step(!m_pend, 8'($urandom), 1'b0);
        end
        check("mid_pre_count", 32'(o_count), 32'd3);
        i_rst   = 1'b1;
        in_reqL = 1'b0;
        in_ackR = 1'b0;
        #1;
        check("mid_rst_count", 32'(o_count),  32'd0);
        check("mid_rst_ackL",  32'(out_ackL), 32'd0);
        check("mid_rst_reqR",  32'(out_reqR), 32'd0);
        check("mid_rst_dataR", 32'(out_dataR), 32'd0);
        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        check("mid_lat_ackL", 32'(out_ackL), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("mid_lat_reqR_early", 32'(out_reqR), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("mid_lat_reqR", 32'(out_reqR), 32'd1);
        check("mid_lat_dataR", 32'(out_dataR), 32'h5A);

        // Randomized legal traffic against the slot model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = !m_pend && ($urandom_range(0, 1) == 1);
            a = m_occ[D-1] && ($urandom_range(0, 2) == 0);
            step(r, 8'($urandom), a);
        end
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 8'h00, m_occ[D-1]);
        end
        check("rand_drained", 32'(o_count), 32'd0);
        check("rand_empty_phase", 32'(out_reqR), 32'(in_ackR));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/click_pipe.md
# click_pipe

Parametrised, clocked click-element pipeline: DEPTH cascaded click stages, each with a WIDTH-bit data latch, moving tokens under a two-phase (transition-signalled) bundled-data handshake on both ends. It generalises the single click register: multi-stage depth, a data path, per-stage fire pulses and occupancy reporting. It sits between click-network producers and consumers wherever the asynchronous pipeline has to be buffered, or emulated, inside one synchronous clock domain.

## Interface
Parameters:
- WIDTH, 8, data bits per token (>=1)
- DEPTH, 4, number of click stages (>=1); DEPTH=1 behaves as a single click register with data

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- in_reqL  input  1  left request, two-phase: each toggle offers one token
- in_dataL  input  WIDTH  left data, bundled with in_reqL
- out_ackL  output  1  left acknowledge, two-phase: each toggle consumes one token
- out_reqR  output  1  right request, two-phase
- out_dataR  output  WIDTH  right data, bundled with out_reqR
- in_ackR  input  1  right acknowledge, two-phase
- o_click  output  DEPTH  per-stage fire pulse, bit i high for one cycle when stage i fires
- o_count  output  $clog2(DEPTH+1)  tokens currently held (0..DEPTH)

## Operation
- State per stage i: phase bit ph[i] and data register d[i].
- Boundary phases:
  - ph[-1] = in_reqL (after optional sync).
  - ph[DEPTH] = in_ackR (after optional sync).
- Stage i full iff ph[i] != ph[i+1]; it holds a token not yet taken downstream.
- fire[i] = (ph[i-1] != ph[i]) & (ph[i] == ph[i+1]): the left neighbour offers a token and stage i is empty.
- All fire[i] are evaluated from the current registered state. On the next edge, every firing stage toggles ph[i] and loads d[i] <= d[i-1], with d[-1] = in_dataL.
- Adjacent stages never fire in the same cycle (mutually exclusive conditions); no combinational path crosses a stage.
- Output mapping:
  - out_ackL = ph[0]
  - out_reqR = ph[DEPTH-1]
  - out_dataR = d[DEPTH-1]
  - o_click = registered fire vector
  - o_count = popcount of full stages, combinational from ph and ph[DEPTH]
- Bundled-data rules:
  - Producer holds in_dataL stable from its in_reqL toggle until the matching out_ackL toggle.
  - out_dataR is stable from each out_reqR toggle until in_ackR matches out_reqR.
- Protocol violations: toggling in_reqL again before out_ackL matches, or in_ackR before out_reqR has toggled, are illegal. Behaviour after a violation is unspecified; no lock-up is required to be recoverable except via i_rst.
- Reset state (i_rst high, asynchronous): all ph = 0, all d = 0, o_click = 0, so out_ackL = 0, out_reqR = 0, out_dataR = 0, o_count = 0.
- Reset asserted mid-operation discards all held tokens immediately. Both environments must also return their phases to 0.

## Timing
- Forward latency, empty pipe:
  - in_reqL toggle sampled at edge k -> out_ackL toggles after edge k.
  - out_reqR toggles after edge k+DEPTH-1.
- Backward: in_ackR toggle sampled at edge k -> stage DEPTH-1 becomes empty; stage DEPTH-2 can fire at edge k+1.
- Peak throughput: one token per 2 cycles per stage (alternating fire).
- Full: DEPTH tokens held, o_count = DEPTH, out_ackL stops toggling until the right side acknowledges.
- Empty: o_count = 0, out_reqR equals in_ackR.
- Simultaneous left offer and right ack in one cycle are both accepted when their stages are independent (DEPTH >= 2).
- For DEPTH = 1, stage 0 fires only when both conditions hold on the same sample.

## Configuration
- CLICK_PIPE_SYNC_EN: when defined, in_reqL and in_ackR each pass through a 2-flop synchronizer (reset to 0) before use as ph[-1] and ph[DEPTH]. This adds 2 cycles to every latency above and permits fully asynchronous neighbours. in_dataL is not synchronized; the bundled-data hold rule covers it.
- When not defined, both inputs are used directly and must be synchronous to i_clk.

## Test plan
- Reset: assert i_rst with random inputs -> all outputs 0 immediately, o_count = 0.
- Single token, DEPTH=4, in_ackR=0: toggle in_reqL with in_dataL = 0xA5 -> out_ackL=1 after 1 edge, out_reqR=1 with out_dataR = 0xA5 after 4 edges, o_click pulses bits 0,1,2,3 on successive cycles.
- Fill: hold in_ackR, offer 6 tokens 0x01..0x06 -> exactly 4 accepted, o_count = 4, out_ackL frozen. Then ack 4 times -> 0x01..0x04 delivered in order, 0x05 accepted after the first ack.
- Streaming with immediate ack: 32 tokens -> throughput 1 token per 2 cycles, order and data preserved, no o_click on adjacent bits in the same cycle.
- Mid-operation reset with 3 tokens held -> o_count = 0, all phases 0; a subsequent single token completes with correct latency.
- CLICK_PIPE_SYNC_EN defined: repeat the single-token case -> out_ackL after 3 edges, out_reqR after 6 edges.
